// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - direct-mapped instruction cache tag store and line-fill controller
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pc_if, fetch_en      fetch word address and lookup qualifier
//   ic_flush             one-cycle pulse invalidating every line
//   ic_rreq, ic_radr     line read request (level) and line-aligned address
//   ic_rreq_ack          DRAM accepted the request
//   ic_rdat_m_valid      one 128-bit beat present this cycle
//   ic_ram_wadr_all      instruction RAM 128-bit write address
//   ic_stall*            fetch-stage stall controls (miss/fill, delayed, FIN, FIN2)
module icache_fill_ctrl #(
  parameter int IWIDTH     = 14,
  parameter int BEATS_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:2]               pc_if,
  input  logic                      fetch_en,
  input  logic                      ic_flush,
  output logic                      ic_rreq,
  output logic [31:4+BEATS_LOG2]    ic_radr,
  input  logic                      ic_rreq_ack,
  input  logic                      ic_rdat_m_valid,
  output logic [IWIDTH-3:0]         ic_ram_wadr_all,
  output logic                      ic_stall,
  output logic                      ic_stall_dly,
  output logic                      ic_stall_fin,
  output logic                      ic_stall_fin2
);

  localparam int IDX_LO = 4 + BEATS_LOG2;
  localparam int IDX_W  = IWIDTH + 2 - IDX_LO;
  localparam int TAG_W  = 30 - IWIDTH;
  localparam int LINES  = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_FIN,
    S_FIN2
  } state_t;

  state_t                state;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [IDX_W-1:0]      lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic [BEATS_LOG2-1:0] beat_cnt;
  logic                  flush_pend;
  logic [IWIDTH-3:0]     wadr_q;

  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic                  miss;
  logic                  beat;
  logic                  last_beat;
  logic                  unused_pc_bits;

  assign pc_idx = pc_if[IWIDTH+1:IDX_LO];
  assign pc_tag = pc_if[31:IWIDTH+2];

  // Word-within-line bits never take part in the lookup.
  assign unused_pc_bits = ^pc_if[IDX_LO-1:2];

  assign miss      = fetch_en && (state == S_IDLE) &&
                     (!valid_q[pc_idx] || (tag_mem[pc_idx] != pc_tag));
  assign beat      = (state == S_FILL) && ic_rdat_m_valid;
  assign last_beat = beat && (&beat_cnt);

  // Gated by rst_n so the stall drops the instant reset is applied, even
  // while a fetch is still presented.
  assign ic_stall = rst_n && (miss || (state == S_REQ) || (state == S_FILL));

  // Live address during a beat, otherwise the last beat's address.
  assign ic_ram_wadr_all = beat ? {lat_idx, beat_cnt} : wadr_q;
  assign ic_radr         = {lat_tag, lat_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      valid_q       <= '0;
      lat_idx       <= '0;
      lat_tag       <= '0;
      beat_cnt      <= '0;
      flush_pend    <= 1'b0;
      wadr_q        <= '0;
      ic_rreq       <= 1'b0;
      ic_stall_dly  <= 1'b0;
      ic_stall_fin  <= 1'b0;
      ic_stall_fin2 <= 1'b0;
    end else begin
      ic_stall_dly  <= ic_stall;
      ic_stall_fin  <= 1'b0;
      ic_stall_fin2 <= 1'b0;

      if (ic_flush) begin
        valid_q <= '0;
      end

      if (beat) begin
        wadr_q   <= {lat_idx, beat_cnt};
        beat_cnt <= beat_cnt + BEATS_LOG2'(1);
      end

      case (state)
        S_IDLE: begin
          if (miss) begin
            state      <= S_REQ;
            ic_rreq    <= 1'b1;
            lat_idx    <= pc_idx;
            lat_tag    <= pc_tag;
            flush_pend <= 1'b0;
          end
        end
        S_REQ: begin
          if (ic_flush) begin
            flush_pend <= 1'b1;
          end
          if (ic_rreq_ack) begin
            ic_rreq <= 1'b0;
            state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (ic_flush) begin
            flush_pend <= 1'b1;
          end
          if (last_beat) begin
            // A flush seen at any point of the fill leaves the new line invalid.
            if (!(ic_flush || flush_pend)) begin
              valid_q[lat_idx] <= 1'b1;
            end
            state        <= S_FIN;
            ic_stall_fin <= 1'b1;
          end
        end
        S_FIN: begin
          state         <= S_FIN2;
          ic_stall_fin2 <= 1'b1;
        end
        S_FIN2: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Tags are not reset; a line is only ever a hit once its valid bit is set.
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_mem[lat_idx] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - self-checking bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

  localparam int LINES = 1024;
  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:2] pc_if = '0;
  logic        fetch_en = 1'b0;
  logic        ic_flush = 1'b0;
  logic        ic_rreq;
  logic [31:6] ic_radr;
  logic        ic_rreq_ack = 1'b0;
  logic        ic_rdat_m_valid = 1'b0;
  logic [11:0] ic_ram_wadr_all;
  logic        ic_stall;
  logic        ic_stall_dly;
  logic        ic_stall_fin;
  logic        ic_stall_fin2;

  icache_fill_ctrl #(.IWIDTH(14), .BEATS_LOG2(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_if           (pc_if),
    .fetch_en        (fetch_en),
    .ic_flush        (ic_flush),
    .ic_rreq         (ic_rreq),
    .ic_radr         (ic_radr),
    .ic_rreq_ack     (ic_rreq_ack),
    .ic_rdat_m_valid (ic_rdat_m_valid),
    .ic_ram_wadr_all (ic_ram_wadr_all),
    .ic_stall        (ic_stall),
    .ic_stall_dly    (ic_stall_dly),
    .ic_stall_fin    (ic_stall_fin),
    .ic_stall_fin2   (ic_stall_fin2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: per-line valid flag and tag, indexed by byte address arithmetic.
  bit          mv [LINES];
  int unsigned mt [LINES];
  int unsigned last_wadr;

  logic [31:0] pool [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0100,
                            32'h0000_0140, 32'h1234_5680, 32'h0002_0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic fetch(input logic [31:0] addr, input int ack_dly, input int gap,
                       input int flush_beat, input bit flush_at_miss, input bit stray);
    int unsigned line, idx, tg;
    bit exp_miss, flushed;
    line     = addr / 64;
    idx      = line % LINES;
    tg       = line / LINES;
    exp_miss = !(mv[idx] && (mt[idx] == tg));
    flushed  = 1'b0;

    pc_if    = addr[31:2];
    fetch_en = 1'b1;
    ic_flush = flush_at_miss;
    #1;
    chk("lookup_stall", ic_stall, exp_miss);
    @(negedge clk);
    ic_flush = 1'b0;
    if (flush_at_miss) model_flush();
    if (!exp_miss) return;

    // Jump away: the fill must keep using the latched address.
    pc_if = 30'($urandom);
    #1;
    chk("req_stall_dly", ic_stall_dly, 1);
    for (int d = 0; d <= ack_dly; d++) begin
      ic_rreq_ack     = (d == ack_dly);
      ic_rdat_m_valid = stray && (d != ack_dly);
      #1;
      chk("req_rreq", ic_rreq, 1);
      chk("req_radr", ic_radr, line);
      chk("req_stall", ic_stall, 1);
      chk("req_wadr_hold", ic_ram_wadr_all, last_wadr);
      @(negedge clk);
    end
    ic_rreq_ack     = 1'b0;
    ic_rdat_m_valid = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("fill_gap_rreq", ic_rreq, 0);
        chk("fill_gap_stall", ic_stall, 1);
        chk("fill_gap_wadr", ic_ram_wadr_all, last_wadr);
        @(negedge clk);
      end
      ic_rdat_m_valid = 1'b1;
      if (b == flush_beat) begin
        ic_flush = 1'b1;
        flushed  = 1'b1;
      end
      #1;
      chk("fill_wadr", ic_ram_wadr_all, idx * BEATS + b);
      chk("fill_stall", ic_stall, 1);
      last_wadr = idx * BEATS + b;
      @(negedge clk);
      ic_rdat_m_valid = 1'b0;
      ic_flush        = 1'b0;
    end

    #1;
    chk("fin_pulse", ic_stall_fin, 1);
    chk("fin_fin2", ic_stall_fin2, 0);
    chk("fin_stall", ic_stall, 0);
    chk("fin_stall_dly", ic_stall_dly, 1);
    chk("fin_wadr_hold", ic_ram_wadr_all, last_wadr);
    @(negedge clk);
    #1;
    chk("fin2_pulse", ic_stall_fin2, 1);
    chk("fin2_fin", ic_stall_fin, 0);
    chk("fin2_stall", ic_stall, 0);
    chk("fin2_stall_dly", ic_stall_dly, 0);
    @(negedge clk);

    if (flushed) begin
      model_flush();
    end else begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
  endtask

  task automatic idle_cycle(input bit flush, input bit stray);
    pc_if           = 30'($urandom);
    fetch_en        = 1'b0;
    ic_flush        = flush;
    ic_rdat_m_valid = stray;
    #1;
    chk("idle_stall", ic_stall, 0);
    chk("idle_rreq", ic_rreq, 0);
    chk("idle_wadr_hold", ic_ram_wadr_all, last_wadr);
    @(negedge clk);
    ic_flush        = 1'b0;
    ic_rdat_m_valid = 1'b0;
    if (flush) model_flush();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rreq"}, ic_rreq, 0);
    chk({tag, "_radr"}, ic_radr, 0);
    chk({tag, "_wadr"}, ic_ram_wadr_all, 0);
    chk({tag, "_stall"}, ic_stall, 0);
    chk({tag, "_stall_dly"}, ic_stall_dly, 0);
    chk({tag, "_fin"}, ic_stall_fin, 0);
    chk({tag, "_fin2"}, ic_stall_fin2, 0);
  endtask

  initial begin
    logic [31:0] addr_r;
    int          fb;

    model_flush();
    last_wadr = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_cycle(1'b0, 1'b0);

    // Cold start at 0x100, minimum penalty, then hit
    fetch(32'h0000_0100, 0, 0, -1, 1'b0, 1'b0);
    fetch(32'h0000_0104, 0, 0, -1, 1'b0, 1'b0);

    // Stray beat valid in IDLE
    idle_cycle(1'b0, 1'b1);

    // Delayed ack, gapped beats, stray valids during REQ
    fetch(32'h0000_2040, 5, 1, -1, 1'b0, 1'b1);
    fetch(32'h0000_207c, 0, 0, -1, 1'b0, 1'b0);

    // Conflict on index 0
    fetch(32'h0000_0000, 0, 0, -1, 1'b0, 1'b0);
    fetch(32'h0001_0000, 1, 0, -1, 1'b0, 1'b0);
    fetch(32'h0000_0000, 0, 0, -1, 1'b0, 1'b0);

    // Flush on beat 2: fill completes, line stays invalid
    fetch(32'h0000_0300, 0, 0, 2, 1'b0, 1'b0);
    fetch(32'h0000_0300, 0, 0, -1, 1'b0, 1'b0);
    fetch(32'h0000_0100, 0, 0, -1, 1'b0, 1'b0);

    // Flush coinciding with a miss in IDLE: miss is taken, line becomes valid
    fetch(32'h0000_0400, 2, 0, -1, 1'b1, 1'b0);
    fetch(32'h0000_0408, 0, 0, -1, 1'b0, 1'b0);

    // Asynchronous reset during beat 1
    addr_r   = 32'h0000_0500;
    pc_if    = addr_r[31:2];
    fetch_en = 1'b1;
    #1;
    chk("rst_miss", ic_stall, 1);
    @(negedge clk);
    ic_rreq_ack = 1'b1;
    @(negedge clk);
    ic_rreq_ack     = 1'b0;
    ic_rdat_m_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_beat1_wadr", ic_ram_wadr_all, 20 * BEATS + 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midfill_reset");
    ic_rdat_m_valid = 1'b0;
    fetch_en        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    last_wadr = 0;
    @(negedge clk);
    fetch(addr_r, 0, 0, -1, 1'b0, 1'b0);
    fetch(32'h0000_0400, 0, 0, -1, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 80; it++) begin
      addr_r = pool[$urandom_range(0, 5)] + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end else begin
        fb = -1;
        if ($urandom_range(0, 7) == 0) fb = int'($urandom_range(0, 3));
        fetch(addr_r, int'($urandom_range(0, 5)), int'($urandom_range(0, 1)), fb,
              $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 Parameter IWIDTH, default 14, log2 of instruction RAM depth in 32-bit words.
REQ-002 Parameter BEATS_LOG2, default 2, log2 of 128-bit beats per cache line (default 4 beats / 16 words / 64 B).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_if  input  [31:2]  current fetch word address.
REQ-006 fetch_en  input  1  lookup qualifier; no miss is raised when low.
REQ-007 ic_flush  input  1  one-cycle pulse that invalidates all lines (fence.i).
REQ-008 ic_rreq  output  1  DRAM line read request, level.
REQ-009 ic_radr  output  [31:6+BEATS_LOG2-2]  line-aligned read address.
REQ-010 ic_rreq_ack  input  1  DRAM accepts the request.
REQ-011 ic_rdat_m_valid  input  1  one 128-bit beat presented this cycle.
REQ-012 ic_ram_wadr_all  output  [IWIDTH-3:0]  instruction RAM 128-bit write address.
REQ-013 ic_stall, ic_stall_dly, ic_stall_fin, ic_stall_fin2  output  1 each  fetch-stage stall controls.

Function
REQ-014 Direct-mapped tag store: index = pc_if[IWIDTH+1:4+BEATS_LOG2]; tag = pc_if[31:IWIDTH+2]; one valid bit per line.
REQ-015 Miss = fetch_en & state IDLE & (~valid[index] | tag[index] != tag of pc_if), combinational.
REQ-016 States: IDLE, REQ, FILL, FIN, FIN2; encoding free.
REQ-017 IDLE -> REQ on miss; the cycle of the miss latches the miss index and tag and asserts ic_stall combinationally.
REQ-018 REQ: ic_rreq = 1, ic_radr = {latched tag, latched index}; held stable until ic_rreq_ack; REQ -> FILL on the cycle ic_rreq_ack = 1 (ic_rreq drops the next cycle).
REQ-019 FILL: each ic_rdat_m_valid increments beat counter (BEATS_LOG2 bits, starts at 0); ic_ram_wadr_all = {latched index, beat counter} during the valid cycle.
REQ-020 ic_rdat_m_valid outside FILL is ignored; beats arrive in ascending order only.
REQ-021 On the last beat (counter all-ones with valid): write tag, set valid for that line, FILL -> FIN.
REQ-022 ic_stall = 1 from the miss cycle through the last-beat cycle inclusive; 0 in FIN, FIN2, IDLE.
REQ-023 ic_stall_dly = ic_stall delayed one cycle (registered).
REQ-024 ic_stall_fin = 1 exactly in FIN (first cycle after last beat); ic_stall_fin2 = 1 exactly in FIN2.
REQ-025 FIN -> FIN2 -> IDLE unconditionally; no miss is evaluated in FIN or FIN2.
REQ-026 Minimum miss penalty: miss, ack next cycle, beats back-to-back -> ic_stall high for 2 + 2^BEATS_LOG2 cycles.
REQ-027 ic_flush in IDLE/FIN/FIN2: all valid bits cleared next edge; a miss in the same cycle as ic_flush is still taken.
REQ-028 ic_flush during REQ or FILL: valid bits cleared, fill completes, filled line is left invalid.
REQ-029 pc_if changes (jump) during REQ/FILL do not affect the fill; latched address is used.
REQ-030 ic_ram_wadr_all outside FILL-valid cycles holds its last value; RAM write enable is ic_rdat_m_valid, not this block.

Reset
REQ-031 rst_n low, at any time including mid-fill: state IDLE, all valid bits 0, beat counter 0, ic_rreq 0, ic_radr 0, ic_ram_wadr_all 0, all four stall outputs 0; in-flight fill is abandoned.
REQ-032 Tag contents need not be reset; valid bits alone gate hits.

Verification
REQ-033 Cold start: reset, fetch_en = 1, pc_if = 0x0000_0100>>2 -> ic_stall same cycle, ic_rreq next cycle with ic_radr = line 0x100; ack, 4 valid beats -> ic_ram_wadr_all 0x010..0x013, ic_stall_fin then ic_stall_fin2, then hit (no ic_stall).
REQ-034 Delayed ack (5 cycles) and beats with 1-cycle gaps -> ic_rreq and ic_radr stable throughout REQ; ic_stall held until last beat; exactly 4 RAM addresses emitted.
REQ-035 Conflict: fill 0x0000_0000, then fetch 0x0001_0000 (same index, different tag) -> miss, refill, subsequent fetch of 0x0000_0000 misses again.
REQ-036 ic_flush during FILL beat 2 -> fill completes, FIN/FIN2 pulse, next fetch of same address misses.
REQ-037 rst_n asserted during FILL beat 1 -> all outputs 0 immediately (async), after release same address misses and full fill restarts from beat 0.
REQ-038 ic_rdat_m_valid pulses in IDLE and REQ -> no address change, no state change, no valid bit set.
